bus_chooser: RTL and testbench

- Common-bus source selector for the basic-computer datapath.
- A 3-bit select code chooses one of seven register or memory outputs and places it on the shared 16-bit bus.
- The selected value is registered, so every bus consumer (AR, PC, DR, AC, IR, TR, memory, ALU) sees a glitch-free bus one clock after the select.
- The control unit drives buscode; the register-file outputs feed in directly.

---
 rtl/bus_chooser_pkg.sv | 17 +
 rtl/bus_chooser_if.sv | 29 ++
 rtl/bus_mux8.sv | 27 ++
 rtl/bus_chooser.sv | 51 +++++
 tb/tb_bus_chooser.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/bus_chooser_pkg.sv
// Shared definitions for the common-bus source selector: select codes
// and default datapath widths. Imported by the control unit and the chooser.
package bus_pkg;

    localparam int BUS_DATA_W = 16;
    localparam int BUS_ADDR_W = 12;

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_AR   = 3'd1;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_DR   = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_TR   = 3'd6;
    localparam logic [2:0] BUS_MEM  = 3'd7;

endpackage

// File: rtl/bus_chooser_if.sv
// Common-bus bundle: select code, the seven register/memory sources and
// the registered bus value. The control side drives select and sources;
// the chooser returns the bus.
interface bus_chooser_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
);
    logic [2:0]        buscode;
    logic [ADDR_W-1:0] ar_outdata;
    logic [ADDR_W-1:0] pc_outdata;
    logic [DATA_W-1:0] dr_outdata;
    logic [DATA_W-1:0] ac_outdata;
    logic [DATA_W-1:0] ir_outdata;
    logic [DATA_W-1:0] tr_outdata;
    logic [DATA_W-1:0] mem_outdata;
    logic [DATA_W-1:0] bus_data;

    modport master (
        output buscode, ar_outdata, pc_outdata, dr_outdata,
               ac_outdata, ir_outdata, tr_outdata, mem_outdata,
        input  bus_data
    );

    modport slave (
        input  buscode, ar_outdata, pc_outdata, dr_outdata,
               ac_outdata, ir_outdata, tr_outdata, mem_outdata,
        output bus_data
    );
endinterface

// File: rtl/bus_mux8.sv
// Combinational 8:1 mux of DATA_W-wide words. An unknown select is not
// resolved to any source: the output goes X so the fault stays visible.
module bus_mux8 #(
    parameter int DATA_W = 16
) (
    input  logic [2:0]             sel,
    input  logic [7:0][DATA_W-1:0] din,
    output logic [DATA_W-1:0]      dout
);

    // Pick exactly one word per code; no priority between inputs.
    always_comb begin
        dout = 'x;
        case (sel)
            3'd0:    dout = din[0];
            3'd1:    dout = din[1];
            3'd2:    dout = din[2];
            3'd3:    dout = din[3];
            3'd4:    dout = din[4];
            3'd5:    dout = din[5];
            3'd6:    dout = din[6];
            3'd7:    dout = din[7];
            default: dout = 'x;
        endcase
    end

endmodule

// File: rtl/bus_chooser.sv
// Common-bus source selector. Zero-extends the address-width sources,
// selects one source by buscode and registers it so every bus consumer
// sees a clean value one clock after the select.
module bus_chooser
    import bus_pkg::*;
#(
    parameter int DATA_W = BUS_DATA_W,
    parameter int ADDR_W = BUS_ADDR_W
) (
    input  logic          CLK,
    input  logic          RST_N,
    bus_chooser_if.slave  bus
);

    logic [7:0][DATA_W-1:0] src_p0;
    logic [DATA_W-1:0]      sel_p0;
    logic [DATA_W-1:0]      bus_p1;

    // Place each source in its code slot; AR/PC get zero upper bits.
    always_comb begin
        src_p0           = '0;
        src_p0[BUS_NONE] = '0;
        src_p0[BUS_AR]   = DATA_W'(bus.ar_outdata);
        src_p0[BUS_PC]   = DATA_W'(bus.pc_outdata);
        src_p0[BUS_DR]   = bus.dr_outdata;
        src_p0[BUS_AC]   = bus.ac_outdata;
        src_p0[BUS_IR]   = bus.ir_outdata;
        src_p0[BUS_TR]   = bus.tr_outdata;
        src_p0[BUS_MEM]  = bus.mem_outdata;
    end

    bus_mux8 #(
        .DATA_W (DATA_W)
    ) u_mux (
        .sel  (bus.buscode),
        .din  (src_p0),
        .dout (sel_p0)
    );

    // ---- stage p0 -> p1: bus register, loads every edge, async clear ----
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bus_p1 <= '0;
        end else begin
            bus_p1 <= sel_p0;
        end
    end

    assign bus.bus_data = bus_p1;

endmodule

// File: tb/tb_bus_chooser.sv
// Bench for bus_chooser: directed test-plan steps with literal
// expectations, then randomized traffic and reset pulses checked every
// cycle against a source-table reference model.
module tb_bus_chooser;

    logic CLK;
    logic RST_N;
    int   checks;
    int   failures;
    bit   chk_en;
    logic [15:0] exp_bus;

    bus_chooser_if #(.DATA_W(16), .ADDR_W(12)) bus ();

    bus_chooser #(.DATA_W(16), .ADDR_W(12)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: the bus is whatever the source table holds at the code.
    function automatic logic [15:0] pick(input logic [2:0] code);
        logic [15:0] table_v [8];
        table_v[0] = 16'h0000;
        table_v[1] = {4'h0, bus.ar_outdata};
        table_v[2] = {4'h0, bus.pc_outdata};
        table_v[3] = bus.dr_outdata;
        table_v[4] = bus.ac_outdata;
        table_v[5] = bus.ir_outdata;
        table_v[6] = bus.tr_outdata;
        table_v[7] = bus.mem_outdata;
        return table_v[code];
    endfunction

    // Expected bus: cleared while reset is low, else last edge's pick.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) exp_bus <= 16'h0000;
        else        exp_bus <= pick(bus.buscode);
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the rising edge.
    always @(negedge CLK) begin
        if (chk_en) check("model", bus.bus_data, exp_bus);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        chk_en   = 1'b0;
        RST_N    = 1'b1;
        bus.buscode     = 3'd7;
        bus.ar_outdata  = 12'h001;
        bus.pc_outdata  = 12'h002;
        bus.dr_outdata  = 16'h0003;
        bus.ac_outdata  = 16'h0004;
        bus.ir_outdata  = 16'h0005;
        bus.tr_outdata  = 16'h0006;
        bus.mem_outdata = 16'h0007;

        // Reset takes effect before any clock edge.
        #1 RST_N = 1'b0;
        #2 check("reset_no_clock", bus.bus_data, 16'h0000);
        tick();
        tick();
        check("reset_held", bus.bus_data, 16'h0000);
        RST_N = 1'b1;
        tick();
        check("reset_release", bus.bus_data, 16'h0007);
        chk_en = 1'b1;

        // Sweep codes 1..7, then 0.
        for (int c = 1; c < 8; c++) begin
            bus.buscode = 3'(c);
            tick();
            check($sformatf("sweep_%0d", c), bus.bus_data, 16'(c));
        end
        bus.buscode = 3'd0;
        tick();
        check("sweep_0", bus.bus_data, 16'h0000);

        // Zero extension of address-width sources.
        bus.ar_outdata = 12'hFFF;
        bus.buscode    = 3'd1;
        tick();
        check("zext_ar", bus.bus_data, 16'h0FFF);
        bus.pc_outdata = 12'hABC;
        bus.buscode    = 3'd2;
        tick();
        check("zext_pc", bus.bus_data, 16'h0ABC);

        // Latency and hold: source change shows only after the next edge.
        bus.buscode    = 3'd6;
        bus.tr_outdata = 16'h0006;
        tick();
        check("hold_before", bus.bus_data, 16'h0006);
        bus.tr_outdata = 16'hBEEF;
        #3 check("hold_between", bus.bus_data, 16'h0006);
        tick();
        check("hold_after", bus.bus_data, 16'hBEEF);

        // Asynchronous reset mid-stream.
        bus.buscode = 3'd7;
        tick();
        check("mid_pre", bus.bus_data, 16'h0007);
        #2 RST_N = 1'b0;
        #1 check("mid_async", bus.bus_data, 16'h0000);
        #2 RST_N = 1'b1;
        tick();
        check("mid_recover", bus.bus_data, 16'h0007);

        // Randomized traffic with occasional reset pulses.
        for (int i = 0; i < 400; i++) begin
            bus.buscode     = 3'($urandom_range(0, 7));
            bus.ar_outdata  = 12'($urandom);
            bus.pc_outdata  = 12'($urandom);
            bus.dr_outdata  = 16'($urandom);
            bus.ac_outdata  = 16'($urandom);
            bus.ir_outdata  = 16'($urandom);
            bus.tr_outdata  = 16'($urandom);
            bus.mem_outdata = 16'($urandom);
            if ($urandom_range(0, 31) == 0) begin
                #2 RST_N = 1'b0;
                #1 check("rand_async", bus.bus_data, 16'h0000);
                #2 RST_N = 1'b1;
            end
            tick();
        end

        chk_en = 1'b0;
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
